// File: rtl/video_timing_gen_dual.sv
// video_timing_gen_dual: dual-mode raster timing generator with pixel enable,
// frame-boundary mode switching, configurable sync polarity and frame counter.
module video_timing_gen_dual #(
    parameter int   ACTIVE_H_A      = 1280,
    parameter int   ACTIVE_H_B      = 640,
    parameter int   H_FRONT_PORCH_A = 110,
    parameter int   H_FRONT_PORCH_B = 16,
    parameter int   H_SYNC_WIDTH_A  = 40,
    parameter int   H_SYNC_WIDTH_B  = 96,
    parameter int   H_BACK_PORCH_A  = 220,
    parameter int   H_BACK_PORCH_B  = 48,
    parameter int   ACTIVE_LINES_A  = 720,
    parameter int   ACTIVE_LINES_B  = 480,
    parameter int   V_FRONT_PORCH_A = 5,
    parameter int   V_FRONT_PORCH_B = 10,
    parameter int   V_SYNC_WIDTH_A  = 5,
    parameter int   V_SYNC_WIDTH_B  = 2,
    parameter int   V_BACK_PORCH_A  = 20,
    parameter int   V_BACK_PORCH_B  = 33,
    parameter logic HS_POL          = 1'b1,
    parameter logic VS_POL          = 1'b1,
    parameter int   FC_WRAP         = 60,
    localparam int  TP_A = ACTIVE_H_A + H_FRONT_PORCH_A + H_SYNC_WIDTH_A + H_BACK_PORCH_A,
    localparam int  TP_B = ACTIVE_H_B + H_FRONT_PORCH_B + H_SYNC_WIDTH_B + H_BACK_PORCH_B,
    localparam int  TL_A = ACTIVE_LINES_A + V_FRONT_PORCH_A + V_SYNC_WIDTH_A + V_BACK_PORCH_A,
    localparam int  TL_B = ACTIVE_LINES_B + V_FRONT_PORCH_B + V_SYNC_WIDTH_B + V_BACK_PORCH_B,
    localparam int  HW   = $clog2(TP_A > TP_B ? TP_A : TP_B),
    localparam int  VW   = $clog2(TL_A > TL_B ? TL_A : TL_B),
    localparam int  FW   = $clog2(FC_WRAP)
) (
    input  logic          clk_pixel_in,
    input  logic          rst_n_in,
    input  logic          enable_in,
    input  logic          mode_sel_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic          nl_out,
    output logic [FW-1:0] fc_out,
    output logic          mode_out
);
    localparam logic [HW-1:0] TPM1_A = HW'(TP_A - 1);
    localparam logic [HW-1:0] TPM1_B = HW'(TP_B - 1);
    localparam logic [VW-1:0] TLM1_A = VW'(TL_A - 1);
    localparam logic [VW-1:0] TLM1_B = VW'(TL_B - 1);
    localparam logic [HW-1:0] AH_A   = HW'(ACTIVE_H_A);
    localparam logic [HW-1:0] AH_B   = HW'(ACTIVE_H_B);
    localparam logic [HW-1:0] HS0_A  = HW'(ACTIVE_H_A + H_FRONT_PORCH_A);
    localparam logic [HW-1:0] HS0_B  = HW'(ACTIVE_H_B + H_FRONT_PORCH_B);
    localparam logic [HW-1:0] HS1_A  = HW'(ACTIVE_H_A + H_FRONT_PORCH_A + H_SYNC_WIDTH_A);
    localparam logic [HW-1:0] HS1_B  = HW'(ACTIVE_H_B + H_FRONT_PORCH_B + H_SYNC_WIDTH_B);
    localparam logic [VW-1:0] AL_A   = VW'(ACTIVE_LINES_A);
    localparam logic [VW-1:0] AL_B   = VW'(ACTIVE_LINES_B);
    localparam logic [VW-1:0] VS0_A  = VW'(ACTIVE_LINES_A + V_FRONT_PORCH_A);
    localparam logic [VW-1:0] VS0_B  = VW'(ACTIVE_LINES_B + V_FRONT_PORCH_B);
    localparam logic [VW-1:0] VS1_A  = VW'(ACTIVE_LINES_A + V_FRONT_PORCH_A + V_SYNC_WIDTH_A);
    localparam logic [VW-1:0] VS1_B  = VW'(ACTIVE_LINES_B + V_FRONT_PORCH_B + V_SYNC_WIDTH_B);
    localparam logic [FW-1:0] FCM1   = FW'(FC_WRAP - 1);

    typedef enum logic {ST_START, ST_RUN} state_t;

    state_t        r_state, w_state_nx;
    logic [HW-1:0] r_hcount, w_h_nx, w_ah, w_hs0, w_hs1;
    logic [VW-1:0] r_vcount, w_v_nx, w_al, w_vs0, w_vs1;
    logic [FW-1:0] r_fc, w_fc_nx;
    logic          r_hs, r_vs, r_ad, r_nf, r_nl, r_mode;
    logic          w_h_end, w_v_end, w_mode_nx, w_nf;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ST_START;
        else           r_state <= w_state_nx;
    end

    // A pending switch request is simply mode_sel_in != mode_out; sampling it
    // on the wrap edge honours requests that arrive on that very edge and
    // drops requests that were withdrawn before it.
    always_comb begin
        w_state_nx = enable_in ? ST_RUN : r_state;
        w_h_end    = r_hcount == (r_mode ? TPM1_B : TPM1_A);
        w_v_end    = r_vcount == (r_mode ? TLM1_B : TLM1_A);
        w_h_nx     = '0;
        w_v_nx     = '0;
        w_mode_nx  = mode_sel_in;
        if (r_state == ST_RUN) begin
            w_h_nx    = w_h_end ? '0 : r_hcount + 1'b1;
            w_v_nx    = !w_h_end ? r_vcount : w_v_end ? '0 : r_vcount + 1'b1;
            w_mode_nx = (w_h_end && w_v_end) ? mode_sel_in : r_mode;
        end
        w_ah    = w_mode_nx ? AH_B  : AH_A;
        w_hs0   = w_mode_nx ? HS0_B : HS0_A;
        w_hs1   = w_mode_nx ? HS1_B : HS1_A;
        w_al    = w_mode_nx ? AL_B  : AL_A;
        w_vs0   = w_mode_nx ? VS0_B : VS0_A;
        w_vs1   = w_mode_nx ? VS1_B : VS1_A;
        w_nf    = (w_h_nx == w_ah) && (w_v_nx == w_al);
        w_fc_nx = !w_nf ? r_fc : (r_fc == FCM1) ? '0 : r_fc + 1'b1;
    end

    // Decode uses the next position so every output matches the count it sits beside.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hs     <= ~HS_POL;
            r_vs     <= ~VS_POL;
            r_ad     <= 1'b0;
            r_nf     <= 1'b0;
            r_nl     <= 1'b0;
            r_fc     <= '0;
            r_mode   <= 1'b0;
        end else if (enable_in) begin
            r_hcount <= w_h_nx;
            r_vcount <= w_v_nx;
            r_hs     <= (w_h_nx >= w_hs0 && w_h_nx < w_hs1) ? HS_POL : ~HS_POL;
            r_vs     <= (w_v_nx >= w_vs0 && w_v_nx < w_vs1) ? VS_POL : ~VS_POL;
            r_ad     <= (w_h_nx < w_ah) && (w_v_nx < w_al);
            r_nf     <= w_nf;
            r_nl     <= w_h_nx == '0;
            r_fc     <= w_fc_nx;
            r_mode   <= w_mode_nx;
        end else begin
            r_nf     <= 1'b0;
            r_nl     <= 1'b0;
        end
    end

    assign hcount_out = r_hcount;
    assign vcount_out = r_vcount;
    assign hs_out     = r_hs;
    assign vs_out     = r_vs;
    assign ad_out     = r_ad;
    assign nf_out     = r_nf;
    assign nl_out     = r_nl;
    assign fc_out     = r_fc;
    assign mode_out   = r_mode;
endmodule

// File: tb/tb_video_timing_gen_dual.sv
// tb_video_timing_gen_dual: random and directed stimulus against a linear-position
// frame model, on one instance with high sync polarity and one with low.
module tb_video_timing_gen_dual;
    localparam int TP  [2] = '{14, 7};
    localparam int TL  [2] = '{7, 5};
    localparam int AH  [2] = '{8, 4};
    localparam int AL  [2] = '{4, 2};
    localparam int HSS [2] = '{10, 5};
    localparam int HSW [2] = '{2, 1};
    localparam int VSS [2] = '{5, 3};
    localparam int VSW [2] = '{1, 1};
    localparam int FCW = 3;

    logic clk = 1'b0;
    logic rst_n, en, sel;
    logic [3:0] hc, hc_n;
    logic [2:0] vc, vc_n;
    logic [1:0] fc, fc_n;
    logic hs, vs, ad, nf, nl, md;
    logic hs_n, vs_n, ad_n, nf_n, nl_n, md_n;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    video_timing_gen_dual #(
        .ACTIVE_H_A(8), .H_FRONT_PORCH_A(2), .H_SYNC_WIDTH_A(2), .H_BACK_PORCH_A(2),
        .ACTIVE_LINES_A(4), .V_FRONT_PORCH_A(1), .V_SYNC_WIDTH_A(1), .V_BACK_PORCH_A(1),
        .ACTIVE_H_B(4), .H_FRONT_PORCH_B(1), .H_SYNC_WIDTH_B(1), .H_BACK_PORCH_B(1),
        .ACTIVE_LINES_B(2), .V_FRONT_PORCH_B(1), .V_SYNC_WIDTH_B(1), .V_BACK_PORCH_B(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .FC_WRAP(3)
    ) dut (
        .clk_pixel_in(clk), .rst_n_in(rst_n), .enable_in(en), .mode_sel_in(sel),
        .hcount_out(hc), .vcount_out(vc), .hs_out(hs), .vs_out(vs), .ad_out(ad),
        .nf_out(nf), .nl_out(nl), .fc_out(fc), .mode_out(md)
    );

    video_timing_gen_dual #(
        .ACTIVE_H_A(8), .H_FRONT_PORCH_A(2), .H_SYNC_WIDTH_A(2), .H_BACK_PORCH_A(2),
        .ACTIVE_LINES_A(4), .V_FRONT_PORCH_A(1), .V_SYNC_WIDTH_A(1), .V_BACK_PORCH_A(1),
        .ACTIVE_H_B(4), .H_FRONT_PORCH_B(1), .H_SYNC_WIDTH_B(1), .H_BACK_PORCH_B(1),
        .ACTIVE_LINES_B(2), .V_FRONT_PORCH_B(1), .V_SYNC_WIDTH_B(1), .V_BACK_PORCH_B(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .FC_WRAP(3)
    ) dut_n (
        .clk_pixel_in(clk), .rst_n_in(rst_n), .enable_in(en), .mode_sel_in(sel),
        .hcount_out(hc_n), .vcount_out(vc_n), .hs_out(hs_n), .vs_out(vs_n), .ad_out(ad_n),
        .nf_out(nf_n), .nl_out(nl_n), .fc_out(fc_n), .mode_out(md_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL timeout %s: event not seen, required within cycle limit at t=%0t", nm, $time);
    endtask

    // Model: the frame is a linear sequence of TP*TL pixels; position is a single index.
    int   m_run, m_mode, m_pos, m_fc;
    logic m_nf, m_nl;

    always @(posedge clk or negedge rst_n) begin : model
        int p, mo;
        if (!rst_n) begin
            m_run <= 0; m_mode <= 0; m_pos <= 0; m_fc <= 0; m_nf <= 1'b0; m_nl <= 1'b0;
        end else if (!en) begin
            m_nf <= 1'b0; m_nl <= 1'b0;
        end else if (m_run == 0) begin
            m_run <= 1; m_mode <= int'(sel); m_pos <= 0; m_nl <= 1'b1; m_nf <= 1'b0;
        end else begin
            p  = m_pos + 1;
            mo = m_mode;
            if (p == TP[mo] * TL[mo]) begin
                p  = 0;
                mo = int'(sel);
            end
            m_pos  <= p;
            m_mode <= mo;
            m_nl   <= (p % TP[mo]) == 0;
            m_nf   <= p == AL[mo] * TP[mo] + AH[mo];
            if (p == AL[mo] * TP[mo] + AH[mo]) m_fc <= (m_fc + 1) % FCW;
        end
    end

    always @(negedge clk) begin : cmp
        int h, v;
        logic ad_e, hs_e, vs_e;
        h    = (m_run != 0) ? m_pos % TP[m_mode] : 0;
        v    = (m_run != 0) ? m_pos / TP[m_mode] : 0;
        ad_e = (m_run != 0) && h < AH[m_mode] && v < AL[m_mode];
        hs_e = (m_run != 0) && h >= HSS[m_mode] && h < HSS[m_mode] + HSW[m_mode];
        vs_e = (m_run != 0) && v >= VSS[m_mode] && v < VSS[m_mode] + VSW[m_mode];
        chk("hcount", hc, h);
        chk("vcount", vc, v);
        chk("hs", hs, hs_e);
        chk("vs", vs, vs_e);
        chk("ad", ad, ad_e);
        chk("nf", nf, m_nf);
        chk("nl", nl, m_nl);
        chk("fc", fc, m_fc);
        chk("mode", md, m_mode);
        chk("hcount_n", hc_n, h);
        chk("vcount_n", vc_n, v);
        chk("hs_n", hs_n, !hs_e);
        chk("vs_n", vs_n, !vs_e);
        chk("ad_n", ad_n, ad_e);
        chk("nf_n", nf_n, m_nf);
        chk("nl_n", nl_n, m_nl);
        chk("fc_n", fc_n, m_fc);
        chk("mode_n", md_n, m_mode);
    end

    task automatic wait_pos(input int h, input int v, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (hc == 4'(h) && vc == 3'(v)) return;
        end
        tmo($sformatf("wait_pos_%0d_%0d", h, v));
    endtask

    task automatic wait_nf(input int lim, output int n);
        n = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            n++;
            if (nf === 1'b1) return;
        end
        tmo("wait_nf");
    endtask

    task automatic wait_mode(input logic m, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (md === m) return;
        end
        tmo("wait_mode");
    endtask

    task automatic count_win(input int n, output int c_hs, output int c_vs, output int c_ad,
                             output int c_nl, output int c_nf);
        c_hs = 0; c_vs = 0; c_ad = 0; c_nl = 0; c_nf = 0;
        repeat (n) begin
            @(negedge clk);
            c_hs += int'(hs); c_vs += int'(vs); c_ad += int'(ad);
            c_nl += int'(nl); c_nf += int'(nf);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_h"}, hc, 0);
        chk({tag, "_v"}, vc, 0);
        chk({tag, "_ad"}, ad, 0);
        chk({tag, "_nf"}, nf, 0);
        chk({tag, "_nl"}, nl, 0);
        chk({tag, "_fc"}, fc, 0);
        chk({tag, "_mode"}, md, 0);
        chk({tag, "_hs"}, hs, 0);
        chk({tag, "_vs"}, vs, 0);
        chk({tag, "_hs_n"}, hs_n, 1);
        chk({tag, "_vs_n"}, vs_n, 1);
    endtask

    task automatic chk_start(input string tag);
        @(negedge clk);
        chk({tag, "_h"}, hc, 0);
        chk({tag, "_v"}, vc, 0);
        chk({tag, "_ad"}, ad, 1);
        chk({tag, "_nl"}, nl, 1);
        chk({tag, "_mode"}, md, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required finish before limit");
        $fatal(1);
    end

    initial begin
        int n, c_hs, c_vs, c_ad, c_nl, c_nf;
        int fc_exp [4];
        fc_exp = '{1, 2, 0, 1};
        rst_n = 1'b1; en = 1'b0; sel = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        en = 1'b1;
        rst_n = 1'b1;
        chk_start("start");
        for (int i = 0; i < 4; i++) begin
            wait_nf(200, n);
            chk("nf_h", hc, 8);
            chk("nf_v", vc, 4);
            chk("fc_seq", fc, fc_exp[i]);
            if (i > 0) chk("frame_len_a", n, 98);
        end
        count_win(98, c_hs, c_vs, c_ad, c_nl, c_nf);
        chk("hs_cnt_a", c_hs, 14);
        chk("vs_cnt_a", c_vs, 14);
        chk("ad_cnt_a", c_ad, 32);
        chk("nl_cnt_a", c_nl, 7);
        chk("nf_cnt_a", c_nf, 1);
        wait_pos(3, 2, 200);
        sel = 1'b1;
        wait_pos(13, 6, 200);
        chk("mode_hold", md, 0);
        @(negedge clk);
        chk("mode_sw", md, 1);
        chk("sw_h", hc, 0);
        chk("sw_v", vc, 0);
        wait_nf(100, n);
        chk("nf_h_b", hc, 4);
        chk("nf_v_b", vc, 2);
        wait_nf(100, n);
        chk("frame_len_b", n, 35);
        count_win(35, c_hs, c_vs, c_ad, c_nl, c_nf);
        chk("hs_cnt_b", c_hs, 5);
        chk("vs_cnt_b", c_vs, 7);
        chk("ad_cnt_b", c_ad, 8);
        chk("nl_cnt_b", c_nl, 5);
        chk("nf_cnt_b", c_nf, 1);
        wait_pos(1, 1, 100);
        sel = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b1;
        wait_pos(6, 4, 100);
        @(negedge clk);
        chk("mode_keep", md, 1);
        chk("keep_h", hc, 0);
        wait_pos(0, 1, 100);
        en = 1'b0;
        @(negedge clk);
        chk("hold_nl", nl, 0);
        repeat (4) @(negedge clk);
        chk("hold_h", hc, 0);
        chk("hold_v", vc, 1);
        en = 1'b1;
        @(negedge clk);
        chk("resume_h", hc, 1);
        chk("resume_v", vc, 1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en = $urandom_range(0, 9) < 8;
            if ($urandom_range(0, 39) == 0) sel = ~sel;
        end
        en = 1'b1;
        sel = 1'b0;
        wait_mode(1'b0, 300);
        wait_pos(9, 3, 300);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_start("restart");
        repeat (200) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
